// File: rtl/vproc_xif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vproc_xif_pkg
//  Description : Shared types and helpers for the core-side XIF result
//                receiver (ID count, result bundle, register-file write).
//  Revision    : 1.0 - initial release
// ============================================================================
package vproc_xif_pkg;

   // Default instruction-ID width used by the shared typedefs below.
   localparam int unsigned XIF_ID_W   = 3;
   localparam int unsigned XIF_ID_CNT = 32'd1 << XIF_ID_W;

   // Number of distinct IDs for a given ID width.
   function automatic int unsigned xif_id_cnt(input int unsigned id_w);
      return 32'd1 << id_w;
   endfunction

   // Result channel payload as presented by the coprocessor.
   typedef struct packed {
      logic [XIF_ID_W-1:0] id;
      logic [31:0]         data;
      logic [4:0]          rd;
      logic                we;
      logic                exc;
      logic [5:0]          exccode;
   } xif_result_t;

   // Contents of the one-entry register-file write-back buffer.
   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } rf_wr_t;

endpackage
`default_nettype wire

// File: rtl/vproc_xif_id_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : vproc_xif_id_tracker
//  Description : Bitmap of offloaded instruction IDs still awaiting a result,
//                with a sticky flag for issues that reuse a live ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module vproc_xif_id_tracker
   import vproc_xif_pkg::*;
#(
   parameter int unsigned XIF_ID_W = 3
) (
   input  logic                               clk_i,
   input  logic                               async_rst_ni,
   input  logic                               issue_valid_i,
   input  logic [XIF_ID_W-1:0]                issue_id_i,
   input  logic                               clear_valid_i,
   input  logic [XIF_ID_W-1:0]                clear_id_i,
   input  logic                               err_clear_i,
   output logic [xif_id_cnt(XIF_ID_W)-1:0]    outstanding_o,
   output logic                               err_reissue_o
);

   localparam int unsigned ID_CNT = xif_id_cnt(XIF_ID_W);

   logic [ID_CNT-1:0] outstanding_q;
   logic [ID_CNT-1:0] outstanding_d;
   logic [ID_CNT-1:0] clear_vec;
   logic [ID_CNT-1:0] set_vec;
   logic              reissue_evt;
   logic              err_reissue_q;

   // Clear from an accepted result is applied before the issue set, so a
   // same-cycle result/issue on one ID leaves the bit set without error.
   always_comb begin
      clear_vec = '0;
      set_vec   = '0;
      if (clear_valid_i) clear_vec[clear_id_i] = 1'b1;
      if (issue_valid_i) set_vec[issue_id_i]   = 1'b1;
      outstanding_d = (outstanding_q & ~clear_vec) | set_vec;
      reissue_evt   = issue_valid_i & outstanding_q[issue_id_i] & ~clear_vec[issue_id_i];
   end

   // Outstanding bitmap register.
   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) outstanding_q <= '0;
      else               outstanding_q <= outstanding_d;
   end

   // Sticky reissue flag; an explicit clear beats a same-cycle event.
   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni)    err_reissue_q <= 1'b0;
      else if (err_clear_i) err_reissue_q <= 1'b0;
      else if (reissue_evt) err_reissue_q <= 1'b1;
   end

   assign outstanding_o = outstanding_q;
   assign err_reissue_o = err_reissue_q;

endmodule
`default_nettype wire

// File: rtl/vproc_xif_result_rx.sv
`default_nettype none
// ============================================================================
//  Module      : vproc_xif_result_rx
//  Description : Core-side XIF result receiver. Accepts results for
//                outstanding IDs, buffers register write-backs in a single
//                entry, pulses exceptions and flags protocol violations.
//  Revision    : 1.0 - initial release
// ============================================================================
module vproc_xif_result_rx
   import vproc_xif_pkg::*;
#(
   parameter int unsigned XIF_ID_W       = 3,
   parameter bit          DONT_CARE_ZERO = 1'b0
) (
   input  logic                               clk_i,
   input  logic                               async_rst_ni,
   input  logic                               issue_valid_i,
   input  logic [XIF_ID_W-1:0]                issue_id_i,
   input  logic                               result_valid_i,
   output logic                               result_ready_o,
   input  logic [XIF_ID_W-1:0]                result_id_i,
   input  logic [31:0]                        result_data_i,
   input  logic [4:0]                         result_rd_i,
   input  logic                               result_we_i,
   input  logic                               result_exc_i,
   input  logic [5:0]                         result_exccode_i,
   output logic                               rf_wr_valid_o,
   input  logic                               rf_wr_ready_i,
   output logic [4:0]                         rf_wr_addr_o,
   output logic [31:0]                        rf_wr_data_o,
   output logic                               exc_valid_o,
   output logic [XIF_ID_W-1:0]                exc_id_o,
   output logic [5:0]                         exc_code_o,
   output logic [xif_id_cnt(XIF_ID_W)-1:0]    outstanding_o,
   output logic                               err_unexpected_o,
   output logic                               err_reissue_o,
   input  logic                               err_clear_i
);

   localparam int unsigned ID_CNT = xif_id_cnt(XIF_ID_W);

   logic [ID_CNT-1:0]   outstanding;
   logic                result_accept;
   logic                result_expected;
   logic                unexpected_evt;
   logic                exc_evt;
   logic                wb_load;

   logic                wb_valid_q;
   rf_wr_t              wb_q;
   logic                exc_valid_q;
   logic [XIF_ID_W-1:0] exc_id_q;
   logic [5:0]          exc_code_q;
   logic                err_unexpected_q;

   // The buffer can take a new result when empty or when it drains this cycle.
   assign result_ready_o  = ~wb_valid_q | rf_wr_ready_i;
   assign result_accept   = result_valid_i & result_ready_o;
   // Uses the pre-issue bitmap: a same-cycle issue never makes a result expected.
   assign result_expected = outstanding[result_id_i];
   assign unexpected_evt  = result_accept & ~result_expected;
   assign exc_evt         = result_accept & result_expected & result_exc_i;
   assign wb_load         = result_accept & result_expected & ~result_exc_i
                          & result_we_i & (result_rd_i != 5'd0);

   vproc_xif_id_tracker #(
      .XIF_ID_W (XIF_ID_W)
   ) u_id_tracker (
      .clk_i         (clk_i),
      .async_rst_ni  (async_rst_ni),
      .issue_valid_i (issue_valid_i),
      .issue_id_i    (issue_id_i),
      .clear_valid_i (result_accept & result_expected),
      .clear_id_i    (result_id_i),
      .err_clear_i   (err_clear_i),
      .outstanding_o (outstanding),
      .err_reissue_o (err_reissue_o)
   );

   // Write-back buffer valid: a reload wins over a same-cycle drain.
   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni)      wb_valid_q <= 1'b0;
      else if (wb_load)       wb_valid_q <= 1'b1;
      else if (rf_wr_ready_i) wb_valid_q <= 1'b0;
   end

   // Write-back buffer payload, captured on load only.
   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         wb_q <= '0;
      end else if (wb_load) begin
         wb_q.addr <= result_rd_i;
         wb_q.data <= result_data_i;
      end
   end

   // Exception pulse lasts exactly one cycle after the faulting result.
   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) exc_valid_q <= 1'b0;
      else               exc_valid_q <= exc_evt;
   end

   // Exception ID and code, captured alongside the pulse.
   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         exc_id_q   <= '0;
         exc_code_q <= '0;
      end else if (exc_evt) begin
         exc_id_q   <= result_id_i;
         exc_code_q <= result_exccode_i;
      end
   end

   // Sticky unexpected-result flag; an explicit clear beats a same-cycle event.
   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni)       err_unexpected_q <= 1'b0;
      else if (err_clear_i)    err_unexpected_q <= 1'b0;
      else if (unexpected_evt) err_unexpected_q <= 1'b1;
   end

   assign rf_wr_valid_o    = wb_valid_q;
   assign rf_wr_addr_o     = (DONT_CARE_ZERO && !wb_valid_q)  ? 5'd0  : wb_q.addr;
   assign rf_wr_data_o     = (DONT_CARE_ZERO && !wb_valid_q)  ? 32'd0 : wb_q.data;
   assign exc_valid_o      = exc_valid_q;
   assign exc_id_o         = (DONT_CARE_ZERO && !exc_valid_q) ? '0    : exc_id_q;
   assign exc_code_o       = (DONT_CARE_ZERO && !exc_valid_q) ? 6'd0  : exc_code_q;
   assign outstanding_o    = outstanding;
   assign err_unexpected_o = err_unexpected_q;

endmodule
`default_nettype wire

// File: tb/tb_vproc_xif_result_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vproc_xif_result_rx
//  Description : Self-checking bench for vproc_xif_result_rx: directed
//                scenarios followed by random traffic against a reference
//                model of the receiver's rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vproc_xif_result_rx;

   localparam int unsigned ID_W   = 3;
   localparam int unsigned ID_CNT = 1 << ID_W;

   logic              clk_i = 1'b0;
   logic              async_rst_ni = 1'b0;
   logic              issue_valid_i = 1'b0;
   logic [ID_W-1:0]   issue_id_i = '0;
   logic              result_valid_i = 1'b0;
   logic              result_ready_o;
   logic [ID_W-1:0]   result_id_i = '0;
   logic [31:0]       result_data_i = '0;
   logic [4:0]        result_rd_i = '0;
   logic              result_we_i = 1'b0;
   logic              result_exc_i = 1'b0;
   logic [5:0]        result_exccode_i = '0;
   logic              rf_wr_valid_o;
   logic              rf_wr_ready_i = 1'b0;
   logic [4:0]        rf_wr_addr_o;
   logic [31:0]       rf_wr_data_o;
   logic              exc_valid_o;
   logic [ID_W-1:0]   exc_id_o;
   logic [5:0]        exc_code_o;
   logic [ID_CNT-1:0] outstanding_o;
   logic              err_unexpected_o;
   logic              err_reissue_o;
   logic              err_clear_i = 1'b0;

   int total = 0;
   int bad   = 0;

   // Reference model: set of live IDs, one pending write, one pending exception.
   bit        live [ID_CNT];
   bit        pend_wr;
   bit [4:0]  pend_addr;
   bit [31:0] pend_data;
   bit        pend_exc;
   bit [7:0]  pend_exc_id;
   bit [5:0]  pend_exc_code;
   bit        flag_unexp;
   bit        flag_reiss;

   vproc_xif_result_rx #(
      .XIF_ID_W       (ID_W),
      .DONT_CARE_ZERO (1'b1)
   ) dut (
      .clk_i            (clk_i),
      .async_rst_ni     (async_rst_ni),
      .issue_valid_i    (issue_valid_i),
      .issue_id_i       (issue_id_i),
      .result_valid_i   (result_valid_i),
      .result_ready_o   (result_ready_o),
      .result_id_i      (result_id_i),
      .result_data_i    (result_data_i),
      .result_rd_i      (result_rd_i),
      .result_we_i      (result_we_i),
      .result_exc_i     (result_exc_i),
      .result_exccode_i (result_exccode_i),
      .rf_wr_valid_o    (rf_wr_valid_o),
      .rf_wr_ready_i    (rf_wr_ready_i),
      .rf_wr_addr_o     (rf_wr_addr_o),
      .rf_wr_data_o     (rf_wr_data_o),
      .exc_valid_o      (exc_valid_o),
      .exc_id_o         (exc_id_o),
      .exc_code_o       (exc_code_o),
      .outstanding_o    (outstanding_o),
      .err_unexpected_o (err_unexpected_o),
      .err_reissue_o    (err_reissue_o),
      .err_clear_i      (err_clear_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] live_map();
      logic [31:0] m = '0;
      for (int i = 0; i < ID_CNT; i++) m[i] = live[i];
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ID_CNT; i++) live[i] = 1'b0;
      pend_wr = 0; pend_addr = 0; pend_data = 0;
      pend_exc = 0; pend_exc_id = 0; pend_exc_code = 0;
      flag_unexp = 0; flag_reiss = 0;
   endtask

   task automatic check_outputs(input string ctx);
      chk({ctx, ":outstanding"}, 32'(outstanding_o), live_map());
      chk({ctx, ":rf_valid"},    32'(rf_wr_valid_o), 32'(pend_wr));
      chk({ctx, ":rf_addr"},     32'(rf_wr_addr_o),  pend_wr ? 32'(pend_addr) : 32'd0);
      chk({ctx, ":rf_data"},     rf_wr_data_o,       pend_wr ? pend_data : 32'd0);
      chk({ctx, ":exc_valid"},   32'(exc_valid_o),   32'(pend_exc));
      chk({ctx, ":exc_id"},      32'(exc_id_o),      pend_exc ? 32'(pend_exc_id) : 32'd0);
      chk({ctx, ":exc_code"},    32'(exc_code_o),    pend_exc ? 32'(pend_exc_code) : 32'd0);
      chk({ctx, ":err_unexp"},   32'(err_unexpected_o), 32'(flag_unexp));
      chk({ctx, ":err_reiss"},   32'(err_reissue_o),    32'(flag_reiss));
   endtask

   // One clock: predict from the current inputs, advance, compare.
   task automatic cycle(input string ctx);
      bit rdy, take, known, freed;
      bit new_unexp, new_reiss;
      #1;
      rdy  = !pend_wr || rf_wr_ready_i;
      chk({ctx, ":ready"}, 32'(result_ready_o), 32'(rdy));
      take  = result_valid_i && rdy;
      known = live[result_id_i];
      freed = take && known;
      new_unexp = take && !known;
      new_reiss = issue_valid_i && live[issue_id_i] && !(freed && result_id_i == issue_id_i);
      @(posedge clk_i);
      #1;
      if (freed) live[result_id_i] = 1'b0;
      if (issue_valid_i) live[issue_id_i] = 1'b1;
      if (freed && !result_exc_i && result_we_i && result_rd_i != 0) begin
         pend_wr   = 1'b1;
         pend_addr = result_rd_i;
         pend_data = result_data_i;
      end else if (rf_wr_ready_i) begin
         pend_wr = 1'b0;
      end
      pend_exc = freed && result_exc_i;
      if (pend_exc) begin
         pend_exc_id   = 8'(result_id_i);
         pend_exc_code = result_exccode_i;
      end
      flag_unexp = err_clear_i ? 1'b0 : (flag_unexp | new_unexp);
      flag_reiss = err_clear_i ? 1'b0 : (flag_reiss | new_reiss);
      check_outputs(ctx);
   endtask

   task automatic idle();
      issue_valid_i = 0; result_valid_i = 0; err_clear_i = 0;
      result_we_i = 0; result_exc_i = 0;
   endtask

   task automatic send(input int id, input bit we, input int rd, input logic [31:0] data,
                       input bit exc, input int code);
      result_valid_i = 1; result_id_i = ID_W'(id); result_we_i = we;
      result_rd_i = 5'(rd); result_data_i = data;
      result_exc_i = exc; result_exccode_i = 6'(code);
   endtask

   task automatic issue(input int id);
      issue_valid_i = 1; issue_id_i = ID_W'(id);
   endtask

   initial begin
      model_reset();
      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      check_outputs("reset");
      async_rst_ni = 1'b1;

      // Basic write-back
      issue(3); cycle("issue3"); idle();
      rf_wr_ready_i = 1;
      send(3, 1, 5, 32'hDEADBEEF, 0, 0); cycle("wb3"); idle();
      chk("wb3_addr_const", 32'(rf_wr_addr_o), 32'd5);
      chk("wb3_data_const", rf_wr_data_o, 32'hDEADBEEF);
      chk("wb3_outst_bit",  32'(outstanding_o[3]), 32'd0);
      cycle("wb3_drain");

      // Backpressure with two back-to-back results
      issue(1); cycle("issue1"); issue(2); cycle("issue2"); idle();
      rf_wr_ready_i = 0;
      send(1, 1, 7, 32'h1111_0007, 0, 0); cycle("bp_first");
      send(2, 1, 8, 32'h2222_0008, 0, 0); cycle("bp_held");
      chk("bp_ready_low", 32'(result_ready_o), 32'd0);
      chk("bp_rd7", 32'(rf_wr_addr_o), 32'd7);
      rf_wr_ready_i = 1; cycle("bp_swap"); idle();
      chk("bp_rd8", 32'(rf_wr_addr_o), 32'd8);
      cycle("bp_drain");

      // Exception
      issue(4); cycle("issue4"); idle();
      send(4, 1, 9, 32'h0BAD_0BAD, 1, 'h0D); cycle("exc4"); idle();
      chk("exc4_code_const", 32'(exc_code_o), 32'h0D);
      cycle("exc4_end");

      // Unexpected results and clear priority
      send(6, 1, 3, 32'h6, 0, 0); cycle("unexp6"); idle();
      send(6, 1, 3, 32'h6, 0, 0); err_clear_i = 1; cycle("unexp_clear"); idle();

      // Reissue, then same-cycle result and issue on one ID
      issue(2); cycle("reiss_a"); issue(2); cycle("reiss_b"); idle();
      err_clear_i = 1; cycle("reiss_clear"); idle();
      send(2, 0, 0, 32'h0, 0, 0); issue(2); cycle("same_cycle"); idle();
      chk("same_cycle_bit", 32'(outstanding_o[2]), 32'd1);
      send(2, 0, 0, 32'h0, 0, 0); cycle("retire2"); idle();

      // Reset with a full write-back buffer
      issue(5); cycle("issue5"); idle(); rf_wr_ready_i = 0;
      send(5, 1, 12, 32'hCAFE_F00D, 0, 0); cycle("fill"); idle();
      #1; async_rst_ni = 0; #1; model_reset(); check_outputs("rst_wb");
      @(posedge clk_i); #1; async_rst_ni = 1; rf_wr_ready_i = 1;
      cycle("rst_wb_after");

      // Reset with an exception pulse pending
      issue(1); cycle("issue1b"); idle();
      send(1, 1, 4, 32'h4, 1, 'h22); cycle("exc1"); idle();
      #1; async_rst_ni = 0; #1; model_reset(); check_outputs("rst_exc");
      @(posedge clk_i); #1; async_rst_ni = 1;
      cycle("rst_exc_after");

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         issue_valid_i    = ($urandom_range(0, 2) != 0);
         issue_id_i       = ID_W'($urandom);
         result_valid_i   = ($urandom_range(0, 1) != 0);
         result_id_i      = ID_W'($urandom);
         result_data_i    = $urandom;
         result_rd_i      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         result_we_i      = ($urandom_range(0, 3) != 0);
         result_exc_i     = ($urandom_range(0, 7) == 0);
         result_exccode_i = 6'($urandom);
         rf_wr_ready_i    = ($urandom_range(0, 2) != 0);
         err_clear_i      = ($urandom_range(0, 15) == 0);
         cycle("rand");
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
